// File: rtl/typer_char_sequencer.sv
// Byte-stream front end for the VGA text typer: FIFO, control-code decode, cursor, one write per glyph.
// Optional TYPER_CLEAR_EN: form feed (0x0C) blanks every cell row-major and homes the cursor.
module typer_char_sequencer #(
  parameter int unsigned NUM_COLS   = 80,
  parameter int unsigned NUM_ROWS   = 60,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       iRST_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] row_num,
  output logic [7:0] col_num,
  output logic [7:0] character_input,
  output logic       start_writing_character,
  input  logic       finished_saving_char,
  output logic [7:0] cursor_row,
  output logic [7:0] cursor_col,
  output logic       busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] COL_LAST = 8'(NUM_COLS - 1);
  localparam logic [7:0] ROW_LAST = 8'(NUM_ROWS - 1);
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
`ifdef TYPER_CLEAR_EN
    S_CLEAR_ISSUE,
    S_CLEAR_WAIT,
`endif
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       row_num_q, row_num_d, col_num_q, col_num_d, char_q, char_d;
  logic             start_q, start_d;
  logic             print_q, print_d;
  logic [7:0]       cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic             busy_q, busy_d;
  logic             push, pop;

  function automatic logic [7:0] row_inc(input logic [7:0] r);
    return (r == ROW_LAST) ? 8'd0 : r + 8'd1;
  endfunction

  // FIFO bookkeeping
  always_comb begin
    push     = char_valid && !full_q;
    pop      = (state_q == S_IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    full_d   = (count_d == CNT_FULL);
  end

  // Decode, cursor and typer handshake
  always_comb begin
    state_d   = state_q;
    byte_d    = pop ? mem_q[rd_ptr_q] : byte_q;
    row_num_d = row_num_q;
    col_num_d = col_num_q;
    char_d    = char_q;
    print_d   = print_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;

    case (state_q)
      S_IDLE: if (pop) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_IDLE;
        if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
          row_num_d = cur_row_q;
          col_num_d = cur_col_q;
          char_d    = byte_q;
          print_d   = 1'b1;
          state_d   = S_ISSUE;
        end else if (byte_q == 8'h0A || byte_q == 8'h0D) begin
          cur_col_d = 8'd0;
          cur_row_d = row_inc(cur_row_q);
        end else if (byte_q == 8'h08) begin
          // Backspace moves first, then blanks the cell it landed on
          if (cur_col_q != 8'd0) begin
            cur_col_d = cur_col_q - 8'd1;
            row_num_d = cur_row_q;
            col_num_d = cur_col_q - 8'd1;
            char_d    = CH_SPACE;
            print_d   = 1'b0;
            state_d   = S_ISSUE;
          end else if (cur_row_q != 8'd0) begin
            cur_row_d = cur_row_q - 8'd1;
            cur_col_d = COL_LAST;
            row_num_d = cur_row_q - 8'd1;
            col_num_d = COL_LAST;
            char_d    = CH_SPACE;
            print_d   = 1'b0;
            state_d   = S_ISSUE;
          end
`ifdef TYPER_CLEAR_EN
        end else if (byte_q == 8'h0C) begin
          row_num_d = 8'd0;
          col_num_d = 8'd0;
          char_d    = CH_SPACE;
          print_d   = 1'b0;
          state_d   = S_CLEAR_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (finished_saving_char) begin
          if (print_q) begin
            if (cur_col_q == COL_LAST) begin
              cur_col_d = 8'd0;
              cur_row_d = row_inc(cur_row_q);
            end else begin
              cur_col_d = cur_col_q + 8'd1;
            end
          end
          state_d = S_IDLE;
        end
      end
`ifdef TYPER_CLEAR_EN
      S_CLEAR_ISSUE: state_d = S_CLEAR_WAIT;
      // Target registers double as the clear sweep position
      S_CLEAR_WAIT: begin
        if (finished_saving_char) begin
          if (row_num_q == ROW_LAST && col_num_q == COL_LAST) begin
            cur_row_d = 8'd0;
            cur_col_d = 8'd0;
            state_d   = S_IDLE;
          end else begin
            if (col_num_q == COL_LAST) begin
              col_num_d = 8'd0;
              row_num_d = row_num_q + 8'd1;
            end else begin
              col_num_d = col_num_q + 8'd1;
            end
            state_d = S_CLEAR_ISSUE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef TYPER_CLEAR_EN
    start_d = (state_d == S_ISSUE) || (state_d == S_CLEAR_ISSUE);
`else
    start_d = (state_d == S_ISSUE);
`endif
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // Byte storage needs no reset; occupancy lives in count_q
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= char_in;
  end

  always_ff @(posedge clock or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      byte_q    <= 8'd0;
      row_num_q <= 8'd0;
      col_num_q <= 8'd0;
      char_q    <= 8'd0;
      start_q   <= 1'b0;
      print_q   <= 1'b0;
      cur_row_q <= 8'd0;
      cur_col_q <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      byte_q    <= byte_d;
      row_num_q <= row_num_d;
      col_num_q <= col_num_d;
      char_q    <= char_d;
      start_q   <= start_d;
      print_q   <= print_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      busy_q    <= busy_d;
    end
  end

  assign char_ready              = ~full_q;
  assign row_num                 = row_num_q;
  assign col_num                 = col_num_q;
  assign character_input         = char_q;
  assign start_writing_character = start_q;
  assign cursor_row              = cur_row_q;
  assign cursor_col              = cur_col_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_typer_char_sequencer.sv
// Self-checking bench for typer_char_sequencer: typer responder, cursor/write reference model, scenario tasks.
`timescale 1ns/1ps
module tb_typer_char_sequencer;

  localparam int NC = 80;
  localparam int NR = 60;

  logic       clock = 1'b0;
  logic       iRST_n = 1'b0;
  logic [7:0] char_in = 8'd0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] row_num, col_num, character_input;
  logic       start_writing_character;
  logic       finished_saving_char;
  logic [7:0] cursor_row, cursor_col;
  logic       busy;

  int  tests = 0;
  int  fails = 0;
  int  start_cnt = 0;
  int  fin_cnt = 0;
  int  resp_cnt = 0;
  int  typer_delay = 5;
  bit  typer_hold = 1'b0;
  int  mrow = 0;
  int  mcol = 0;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];

  typer_char_sequencer dut (
    .clock(clock), .iRST_n(iRST_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .row_num(row_num), .col_num(col_num),
    .character_input(character_input), .start_writing_character(start_writing_character),
    .finished_saving_char(finished_saving_char), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clock = ~clock;

  // Typer model: records each start, answers with one completion pulse typer_delay cycles later
  initial begin
    finished_saving_char = 1'b0;
    forever begin
      @(negedge clock);
      finished_saving_char = 1'b0;
      if (resp_cnt > 0 && !typer_hold) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          finished_saving_char = 1'b1;
          fin_cnt++;
        end
      end
      if (start_writing_character === 1'b1) begin
        obs_q.push_back({row_num, col_num, character_input});
        start_cnt++;
        resp_cnt = typer_delay;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required clean finish");
    $fatal(1, "watchdog");
  end

  // Reference model: what each accepted byte does to the screen and cursor
  task automatic model_newline();
    mcol = 0;
    mrow = (mrow == NR - 1) ? 0 : mrow + 1;
  endtask

  task automatic apply_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({8'(mrow), 8'(mcol), b});
      if (mcol == NC - 1) model_newline();
      else mcol++;
    end else if (b == 8'h0A || b == 8'h0D) begin
      model_newline();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        exp_q.push_back({8'(mrow), 8'(mcol), 8'h20});
      end else if (mrow > 0) begin
        mrow--;
        mcol = NC - 1;
        exp_q.push_back({8'(mrow), 8'(mcol), 8'h20});
      end
`ifdef TYPER_CLEAR_EN
    end else if (b == 8'h0C) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          exp_q.push_back({8'(r), 8'(c), 8'h20});
      mrow = 0;
      mcol = 0;
`endif
    end
  endtask

  // Offer one byte until accepted; tasks enter and leave 1 ns after a rising edge
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   done;
    done = 1'b0;
    char_in = b;
    char_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      rdy = char_ready;
      @(posedge clock); #1;
      if (rdy) begin
        done = 1'b1;
        apply_byte(b);
      end
    end
    char_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: byte %h not accepted, char_ready=%b required 1", b, char_ready);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock); #1;
      if (busy === 1'b0 && resp_cnt == 0) ok = 1'b1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy=%b resp_cnt=%0d required busy=0", busy, resp_cnt);
    end
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({cursor_row, cursor_col, row_num, col_num, character_input} !== 40'h0) begin
      fails++;
      $display("FAIL reset_regs: got %h required 0", {cursor_row, cursor_col, row_num, col_num, character_input});
    end
    tests++;
    if ({start_writing_character, busy, char_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset_flags: start/busy/ready got %b required 001", {start_writing_character, busy, char_ready});
    end
    @(posedge clock); @(posedge clock); #1;
    iRST_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_char();
    logic [23:0] tgt;
    clear_queues();
    send_byte(8'h41);
    tests++;
    if (start_writing_character !== 1'b0) begin
      fails++; $display("FAIL latency_n1: start got %b required 0", start_writing_character);
    end
    @(posedge clock); #1;
    tests++;
    if (start_writing_character !== 1'b0) begin
      fails++; $display("FAIL latency_n2: start got %b required 0", start_writing_character);
    end
    @(posedge clock); #1;
    tgt = {row_num, col_num, character_input};
    tests++;
    if (start_writing_character !== 1'b1 || tgt !== 24'h000041) begin
      fails++; $display("FAIL latency_n3: start=%b target=%h required 1 and 000041", start_writing_character, tgt);
    end
    repeat (3) @(posedge clock); #1;
    tests++;
    if (start_writing_character !== 1'b0 || busy !== 1'b1 || {row_num, col_num, character_input} !== 24'h000041) begin
      fails++;
      $display("FAIL wait_hold: start=%b busy=%b target=%h required 0,1,000041",
               start_writing_character, busy, {row_num, col_num, character_input});
    end
    wait_idle(100);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd0, 8'd1}) begin
      fails++; $display("FAIL single_cursor: got (%0d,%0d) required (0,1)", cursor_row, cursor_col);
    end
    clear_queues();
  endtask

  task automatic test_cursor_wrap();
    int s0, bad, first;
    clear_queues();
    for (int i = 0; i < 78; i++) send_byte(8'($urandom_range(32, 126)));
    wait_idle(2000);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd0, 8'd79}) begin
      fails++; $display("FAIL cursor_0_79: got (%0d,%0d) required (0,79)", cursor_row, cursor_col);
    end
    send_byte(8'h42);
    wait_idle(100);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd1, 8'd0}) begin
      fails++; $display("FAIL wrap_col: got (%0d,%0d) required (1,0)", cursor_row, cursor_col);
    end
    send_byte(8'h08);
    wait_idle(100);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd0, 8'd79} || obs_q[$] !== 24'h004F20) begin
      fails++;
      $display("FAIL bs_row_up: cursor (%0d,%0d) last write %h required (0,79) and 004f20",
               cursor_row, cursor_col, obs_q[$]);
    end
    for (int i = 0; i < 59; i++) send_byte(8'h0A);
    for (int i = 0; i < 79; i++) send_byte(8'($urandom_range(32, 126)));
    wait_idle(2000);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd59, 8'd79}) begin
      fails++; $display("FAIL cursor_59_79: got (%0d,%0d) required (59,79)", cursor_row, cursor_col);
    end
    send_byte(8'h43);
    wait_idle(100);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd0, 8'd0}) begin
      fails++; $display("FAIL wrap_screen: got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
    s0 = start_cnt;
    send_byte(8'h08);
    repeat (10) @(posedge clock); #1;
    tests++;
    if (start_cnt != s0 || {cursor_row, cursor_col} !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bs_origin: starts +%0d cursor (%0d,%0d) busy %b required +0 (0,0) 0",
               start_cnt - s0, cursor_row, cursor_col, busy);
    end
    bad = 0; first = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_writes: %0d writes, %0d differ (first %0d), required %0d matching",
               obs_q.size(), bad, first, exp_q.size());
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes[20];
    logic rdy;
    int idx, f0, bad, first;
    clear_queues();
    typer_hold = 1'b1;
    f0 = start_cnt;
    send_byte(8'h61);
    for (int i = 0; i < 20 && start_cnt == f0; i++) begin @(posedge clock); #1; end
    for (int i = 0; i < 20; i++) bytes[i] = 8'($urandom_range(32, 126));
    idx = 0;
    for (int i = 0; i < 40 && idx < 20; i++) begin
      char_in = bytes[idx]; char_valid = 1'b1;
      rdy = char_ready;
      @(posedge clock); #1;
      if (rdy) begin apply_byte(bytes[idx]); idx++; end
    end
    tests++;
    if (idx != 16 || char_ready !== 1'b0) begin
      fails++; $display("FAIL fifo_full: accepted %0d ready %b required 16 and 0", idx, char_ready);
    end
    // Let exactly one write complete; the freed slot takes one more byte
    f0 = fin_cnt;
    typer_hold = 1'b0;
    for (int i = 0; i < 30; i++) begin
      char_in = bytes[idx]; char_valid = 1'b1;
      rdy = char_ready;
      @(posedge clock); #1;
      if (rdy) begin apply_byte(bytes[idx]); idx++; end
      if (fin_cnt != f0) typer_hold = 1'b1;
    end
    tests++;
    if (idx != 17 || char_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL refill: accepted %0d ready %b busy %b required 17, 0, 1", idx, char_ready, busy);
    end
    typer_hold = 1'b0;
    while (idx < 20) begin send_byte(bytes[idx]); idx++; end
    wait_idle(2000);
    bad = 0; first = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != 21 || exp_q.size() != 21) begin
      fails++;
      $display("FAIL bp_order: %0d writes, %0d differ (first %0d), required 21 matching", obs_q.size(), bad, first);
    end
    tests++;
    if ({cursor_row, cursor_col} !== {8'(mrow), 8'(mcol)}) begin
      fails++; $display("FAIL bp_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
    end
    clear_queues();
  endtask

  task automatic test_reset_mid_write();
    int s0, f0;
    typer_hold = 1'b1;
    s0 = start_cnt;
    send_byte(8'h5A);
    for (int i = 0; i < 20 && start_cnt == s0; i++) begin @(posedge clock); #1; end
    repeat (2) @(posedge clock); #3;
    iRST_n = 1'b0;
    #1;
    tests++;
    if ({cursor_row, cursor_col, row_num, col_num, character_input} !== 40'h0 ||
        {start_writing_character, busy, char_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset_mid_write: regs %h flags %b required 0 and 001",
               {cursor_row, cursor_col, row_num, col_num, character_input},
               {start_writing_character, busy, char_ready});
    end
    @(posedge clock); #1;
    iRST_n = 1'b1;
    mrow = 0; mcol = 0;
    clear_queues();
    s0 = start_cnt;
    f0 = fin_cnt;
    typer_hold = 1'b0;
    for (int i = 0; i < 20 && fin_cnt == f0; i++) begin @(posedge clock); #1; end
    repeat (5) @(posedge clock); #1;
    tests++;
    if (fin_cnt == f0 || start_cnt != s0 || {cursor_row, cursor_col} !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL late_finish: pulses %0d starts +%0d cursor (%0d,%0d) busy %b required >0 +0 (0,0) 0",
               fin_cnt - f0, start_cnt - s0, cursor_row, cursor_col, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int bad, first;
    clear_queues();
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
        6:                b = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
        7, 8:             b = 8'h08;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0C) b = 8'h0B;
        end
      endcase
      typer_delay = $urandom_range(1, 6);
      send_byte(b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clock);
        #1;
      end
    end
    wait_idle(3000);
    bad = 0; first = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL random_writes: %0d writes, %0d differ (first %0d), required %0d matching",
               obs_q.size(), bad, first, exp_q.size());
    end
    tests++;
    if ({cursor_row, cursor_col} !== {8'(mrow), 8'(mcol)}) begin
      fails++; $display("FAIL random_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
    end
    typer_delay = 5;
    clear_queues();
  endtask

`ifdef TYPER_CLEAR_EN
  task automatic test_clear();
    int bad, first;
    for (int i = 0; i < NR + 1 && mrow != 5; i++) send_byte(8'h0A);
    if (mcol != 0) send_byte(8'h0A);
    while (mrow != 5) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(32, 126)));
    wait_idle(500);
    tests++;
    if ({cursor_row, cursor_col} !== {8'd5, 8'd5}) begin
      fails++; $display("FAIL clear_setup: got (%0d,%0d) required (5,5)", cursor_row, cursor_col);
    end
    clear_queues();
    typer_delay = 1;
    send_byte(8'h0C);
    wait_idle(30000);
    bad = 0; first = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != NR * NC || exp_q.size() != NR * NC) begin
      fails++;
      $display("FAIL clear_writes: %0d writes, %0d differ (first %0d), required %0d matching",
               obs_q.size(), bad, first, NR * NC);
    end
    tests++;
    if ({cursor_row, cursor_col} !== 16'h0) begin
      fails++; $display("FAIL clear_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
    typer_delay = 5;
    clear_queues();
  endtask
`endif

  initial begin
    test_reset();
    test_single_char();
    test_cursor_wrap();
    test_backpressure();
    test_reset_mid_write();
    test_random();
`ifdef TYPER_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
